// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral strobe bus. Only one
// transaction is in flight at a time. Slave strobes and master responses are registered.
module io_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_rd,
  input  logic [3:0]        m0_wr_strobe,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_rd,
  input  logic [3:0]        m1_wr_strobe,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_rd_strobe,
  output logic [3:0]        s_wr_strobe,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a master holds addr/wdata/request level until its mN_done
  // pulse (one cycle), then drops the request; the arbiter samples requests only in IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              is_rd_q;
  logic              last_q;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic              s_rd_strobe_q;
  logic [3:0]        s_wr_strobe_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic              m0_done_q;
  logic              m1_done_q;

  logic              req0;
  logic              req1;
  logic              pick1;
  logic              sel_rd;
  logic [3:0]        sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // last_q holds the index of the previous owner; on a tie the other master wins.
  always_comb begin
    req0      = m0_rd | (|m0_wr_strobe);
    req1      = m1_rd | (|m1_wr_strobe);
    pick1     = req1 & (~req0 | ~last_q);
    sel_rd    = pick1 ? m1_rd        : m0_rd;
    sel_wr    = pick1 ? m1_wr_strobe : m0_wr_strobe;
    sel_addr  = pick1 ? m1_addr      : m0_addr;
    sel_wdata = pick1 ? m1_wdata     : m0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      is_rd_q       <= 1'b0;
      last_q        <= 1'b1;
      grant_q       <= 2'b00;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_rd_strobe_q <= 1'b0;
      s_wr_strobe_q <= 4'h0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      m0_done_q     <= 1'b0;
      m1_done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            grant_q       <= pick1 ? 2'b10 : 2'b01;
            is_rd_q       <= sel_rd;
            s_addr_q      <= sel_addr;
            s_wdata_q     <= sel_wdata;
            // Strobes are launched here so they are high exactly during ISSUE.
            s_rd_strobe_q <= sel_rd;
            s_wr_strobe_q <= sel_rd ? 4'h0 : sel_wr;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          s_rd_strobe_q <= 1'b0;
          s_wr_strobe_q <= 4'h0;
          if (is_rd_q) begin
            cnt_q   <= 4'(RD_LATENCY);
            state_q <= WAIT;
          end else begin
            m0_done_q <= grant_q[0];
            m1_done_q <= grant_q[1];
            state_q   <= DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (grant_q[0]) m0_rdata_q <= s_rdata;
            if (grant_q[1]) m1_rdata_q <= s_rdata;
            m0_done_q <= grant_q[0];
            m1_done_q <= grant_q[1];
            state_q   <= DONE;
          end
        end
        DONE: begin
          m0_done_q <= 1'b0;
          m1_done_q <= 1'b0;
          last_q    <= grant_q[1];
          grant_q   <= 2'b00;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_rd_strobe = s_rd_strobe_q;
  assign s_wr_strobe = s_wr_strobe_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_done     = m0_done_q;
  assign m1_done     = m1_done_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: table of single-master transactions on an
// RD_LATENCY=1 instance, plus fairness, mid-transaction reset and an RD_LATENCY=3 instance.
module tb_io_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A (RD_LATENCY = 1)
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        m0_rd, m0_done, m1_rd, m1_done;
  logic [3:0]  m0_wr_strobe, m1_wr_strobe;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_rd_strobe, busy;
  logic [3:0]  s_wr_strobe;
  logic [1:0]  grant, dbg_state;

  // Instance B (RD_LATENCY = 3), master 1 tied idle
  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_rdata;
  logic        b_m0_rd, b_m0_done, b_m1_done;
  logic [3:0]  b_m0_wr_strobe;
  logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;
  logic        b_s_rd_strobe, b_busy;
  logic [3:0]  b_s_wr_strobe;
  logic [1:0]  b_grant, b_dbg_state;

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rd(m0_rd), .m0_wr_strobe(m0_wr_strobe),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rd(m1_rd), .m1_wr_strobe(m1_wr_strobe),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rd_strobe(s_rd_strobe), .s_wr_strobe(s_wr_strobe),
    .s_rdata(s_rdata), .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_rd(b_m0_rd), .m0_wr_strobe(b_m0_wr_strobe),
    .m0_rdata(b_m0_rdata), .m0_done(b_m0_done),
    .m1_addr(32'h0), .m1_wdata(32'h0), .m1_rd(1'b0), .m1_wr_strobe(4'h0),
    .m1_rdata(b_m1_rdata), .m1_done(b_m1_done),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rd_strobe(b_s_rd_strobe), .s_wr_strobe(b_s_wr_strobe),
    .s_rdata(b_s_rdata), .grant(b_grant), .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // Slave models: byte-lane writes; read data is valid only in the cycle
  // exactly RD_LATENCY after the strobe, junk otherwise.
  logic [31:0] mem_a [16] = '{default: 32'h0};
  logic [31:0] mem_b [16] = '{default: 32'h0};
  logic [3:0]  rcnt_a = 4'd0, rcnt_b = 4'd0;
  logic [3:0]  raddr_a = 4'd0, raddr_b = 4'd0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (s_wr_strobe[b])   mem_a[s_addr[5:2]][8*b +: 8]   <= s_wdata[8*b +: 8];
      if (b_s_wr_strobe[b]) mem_b[b_s_addr[5:2]][8*b +: 8] <= b_s_wdata[8*b +: 8];
    end
    if (s_rd_strobe) begin
      rcnt_a  <= 4'd1;
      raddr_a <= s_addr[5:2];
    end else if (rcnt_a != 4'd0) rcnt_a <= rcnt_a - 4'd1;
    if (b_s_rd_strobe) begin
      rcnt_b  <= 4'd3;
      raddr_b <= b_s_addr[5:2];
    end else if (rcnt_b != 4'd0) rcnt_b <= rcnt_b - 4'd1;
  end

  assign s_rdata   = (rcnt_a == 4'd1) ? mem_a[raddr_a] : 32'hDEAD_BEEF;
  assign b_s_rdata = (rcnt_b == 4'd1) ? mem_b[raddr_b] : 32'hBAAD_F00D;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        who;
    logic        rd;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    int          exp_rd_pulses;
    int          exp_wr_pulses;
    logic [31:0] exp_rdata0;
    logic [31:0] exp_rdata1;
    logic [31:0] exp_mem;
  } vec_t;

  task automatic idle_masters();
    m0_rd = 1'b0; m0_wr_strobe = 4'h0;
    m1_rd = 1'b0; m1_wr_strobe = 4'h0;
  endtask

  // One single-master transaction on instance A, started from IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int         cyc, done_cyc, rd_p, wr_p, wr_cyc;
    logic [1:0] g1;
    logic [3:0] wval;
    logic       other_done;
    cyc = 0; done_cyc = -1; rd_p = 0; wr_p = 0; wr_cyc = -1;
    g1 = 2'b00; wval = 4'h0; other_done = 1'b0;
    if (v.who) begin
      m1_addr = v.addr; m1_wdata = v.wdata; m1_rd = v.rd; m1_wr_strobe = v.wstrb;
    end else begin
      m0_addr = v.addr; m0_wdata = v.wdata; m0_rd = v.rd; m0_wr_strobe = v.wstrb;
    end
    while (done_cyc < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (cyc == 1) g1 = grant;
      if (s_rd_strobe) rd_p++;
      if (s_wr_strobe != 4'h0) begin
        wr_p++; wr_cyc = cyc; wval = s_wr_strobe;
      end
      if (v.who ? m0_done : m1_done) other_done = 1'b1;
      if (v.who ? m1_done : m0_done) done_cyc = cyc;
    end
    idle_masters();
    check($sformatf("v%0d grant", idx), 32'(g1), v.who ? 32'h2 : 32'h1);
    check($sformatf("v%0d done latency", idx), done_cyc, v.exp_lat);
    check($sformatf("v%0d rd pulses", idx), rd_p, v.exp_rd_pulses);
    check($sformatf("v%0d wr pulses", idx), wr_p, v.exp_wr_pulses);
    if (v.exp_wr_pulses != 0) begin
      check($sformatf("v%0d wr strobe cycle", idx), wr_cyc, 1);
      check($sformatf("v%0d wr strobe value", idx), 32'(wval), 32'(v.wstrb));
    end
    check($sformatf("v%0d m0_rdata", idx), m0_rdata, v.exp_rdata0);
    check($sformatf("v%0d m1_rdata", idx), m1_rdata, v.exp_rdata1);
    check($sformatf("v%0d other done", idx), 32'(other_done), 32'h0);
    tick();
    check($sformatf("v%0d slave mem", idx), mem_a[v.addr[5:2]], v.exp_mem);
    check($sformatf("v%0d idle grant/busy", idx), {29'b0, busy, grant}, 32'h0);
    tick();
  endtask

  vec_t vecs[7];
  vec_t vc;
  logic exp_q[$];

  initial begin
    int   cyc, done_cyc, got, rd_cyc;
    logic exp_bit, saw_done;
    logic [1:0] g1;

    idle_masters();
    m0_addr = 32'h0; m0_wdata = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    b_m0_addr = 32'h0; b_m0_wdata = 32'h0; b_m0_rd = 1'b0; b_m0_wr_strobe = 4'h0;

    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h10, 32'h0000_00A5, 2, 0, 1, 32'h0,  32'h0,        32'h0000_00A5};
    vecs[1] = '{1'b0, 1'b1, 4'h0, 32'h10, 32'h0,         3, 1, 0, 32'hA5, 32'h0,        32'h0000_00A5};
    vecs[2] = '{1'b1, 1'b0, 4'h3, 32'h14, 32'h1234_5678, 2, 0, 1, 32'hA5, 32'h0,        32'h0000_5678};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 32'h14, 32'h0,         3, 1, 0, 32'hA5, 32'h5678,     32'h0000_5678};
    vecs[4] = '{1'b0, 1'b0, 4'hC, 32'h14, 32'hAABB_CCDD, 2, 0, 1, 32'hA5, 32'h5678,     32'hAABB_5678};
    vecs[5] = '{1'b1, 1'b1, 4'h3, 32'h10, 32'h0000_FFFF, 3, 1, 0, 32'hA5, 32'hA5,       32'h0000_00A5};
    vecs[6] = '{1'b0, 1'b1, 4'h0, 32'h14, 32'h0,         3, 1, 0, 32'hAABB_5678, 32'hA5, 32'hAABB_5678};

    // Reset state
    tick(); tick();
    check("reset grant/busy/strobes", {24'b0, grant, busy, s_rd_strobe, s_wr_strobe}, 32'h0);
    check("reset done pulses", {30'b0, m1_done, m0_done}, 32'h0);
    check("reset m0_rdata", m0_rdata, 32'h0);
    check("reset dbg_state", 32'(dbg_state), 32'h0);
    check("reset L3 outputs", {27'b0, b_grant, b_busy, b_m0_done, b_m1_done}, 32'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Simultaneous requests right after reset must alternate 0,1,0,1.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(i[0]);
    m0_addr = 32'h10; m0_rd = 1'b1;
    m1_addr = 32'h14; m1_rd = 1'b1;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (m0_done || m1_done) begin
        exp_bit = exp_q.pop_front();
        check($sformatf("rr order %0d", got), {30'b0, m1_done, m0_done}, exp_bit ? 32'h2 : 32'h1);
        got++;
      end
    end
    idle_masters();
    check("rr completions", got, 4);
    tick(); tick();

    // m0 write leaves last grant at master 0, then reset lands mid m1 read.
    vc = '{1'b0, 1'b0, 4'hF, 32'h18, 32'h11, 2, 0, 1, 32'hA5, 32'hAABB_5678, 32'h11};
    run_vec(7, vc);
    m1_addr = 32'h10; m1_rd = 1'b1;
    tick(); tick();
    check("mid-read state WAIT", 32'(dbg_state), 32'h2);
    #1 rst = 1'b0;
    #1;
    check("async reset control outs", {24'b0, grant, busy, s_rd_strobe, s_wr_strobe}, 32'h0);
    check("async reset done", {30'b0, m1_done, m0_done}, 32'h0);
    check("async reset rdata", m0_rdata | m1_rdata, 32'h0);
    check("async reset bus", s_addr | s_wdata, 32'h0);
    m1_rd = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m1_done) saw_done = 1'b1;
    end
    check("no m1_done after reset", 32'(saw_done), 32'h0);
    rst = 1'b1;
    tick();
    m0_addr = 32'h18; m0_rd = 1'b1;
    m1_addr = 32'h10; m1_rd = 1'b1;
    tick();
    check("post-reset first grant", 32'(grant), 32'h1);
    cyc = 1; done_cyc = -1; saw_done = 1'b0;
    if (m0_done) done_cyc = cyc;
    while (done_cyc < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (m1_done) saw_done = 1'b1;
      if (m0_done) done_cyc = cyc;
    end
    idle_masters();
    check("post-reset m0 done latency", done_cyc, 3);
    check("post-reset m0_rdata", m0_rdata, 32'h11);
    check("post-reset m1 not first", 32'(saw_done), 32'h0);
    tick(); tick(); tick();

    // RD_LATENCY = 3 instance: write, then read with exact capture cycle.
    b_m0_addr = 32'h20; b_m0_wdata = 32'hCAFE_F00D; b_m0_wr_strobe = 4'hF;
    cyc = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (b_m0_done) done_cyc = cyc;
    end
    b_m0_wr_strobe = 4'h0;
    check("L3 write done latency", done_cyc, 2);
    tick(); tick();
    b_m0_rd = 1'b1;
    cyc = 0; done_cyc = -1; rd_cyc = -1; g1 = 2'b00;
    while (done_cyc < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (cyc == 1) g1 = b_grant;
      if (b_s_rd_strobe) rd_cyc = cyc;
      if (b_m0_done) done_cyc = cyc;
    end
    b_m0_rd = 1'b0;
    check("L3 grant", 32'(g1), 32'h1);
    check("L3 rd strobe cycle", rd_cyc, 1);
    check("L3 read done latency", done_cyc, 5);
    check("L3 m0_rdata", b_m0_rdata, 32'hCAFE_F00D);
    tick();
    check("L3 idle after read", {27'b0, b_dbg_state, b_busy, b_m1_done, b_m0_done}, 32'h0);
    check("L3 m1_rdata untouched", b_m1_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the peripheral strobe bus (addr / data_in / rd_strobe / wr_strobe[3:0] / data_out) used by the GPIO/LED block.
- Master 0 is the CPU load/store port; master 1 is a secondary requester (debug or pattern engine).
- Round-robin grant; exactly one outstanding transaction.
- Slave strobes are single-cycle pulses from registered state; read data is captured after a fixed slave latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from s_rd_strobe to valid s_rdata. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_rd  in  1  master 0 read request (level).
- m0_wr_strobe  in  4  master 0 byte write request (level; nonzero = write).
- m0_rdata  out  DATA_W  master 0 read data.
- m0_done  out  1  master 0 completion pulse.
- m1_addr, m1_wdata, m1_rd, m1_wr_strobe, m1_rdata, m1_done: same as master 0, for master 1.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_rd_strobe  out  1  slave read pulse.
- s_wr_strobe  out  4  slave write byte strobes.
- s_rdata  in  DATA_W  slave read data.
- grant  out  2  one-hot owner of the current transaction (00 = idle).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including s_rd_strobe, s_wr_strobe, mN_done, mN_rdata and grant.
  - last_grant is set to 1, so master 0 wins the first tie.
- Reset mid-transaction: strobes drop immediately, the transaction is discarded, and no done pulse is issued.
- Request definition: reqN = mN_rd | (|mN_wr_strobe).
- Same-master rd and wr together: treated as a read only; the write strobes are ignored.
- Masters hold addr, wdata and request stable until mN_done, then deassert the request in the following cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the master that is not last_grant.
  - On grant, register addr, wdata, the rd/wr type and grant; next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - s_addr and s_wdata are driven from the registers.
  - Read: s_rd_strobe = 1, load the counter with RD_LATENCY, go to WAIT.
  - Write: s_wr_strobe = the registered strobes, go to DONE.
  - Strobes are 0 in every other state. s_addr and s_wdata hold their last value.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture s_rdata into the granted mN_rdata; next state is DONE.
- DONE (1 cycle):
  - Granted mN_done = 1.
  - last_grant is updated to the granted master.
  - Next state is IDLE. grant clears on entry to IDLE.
- Latency from the IDLE grant cycle (cycle 0):
  - Write: strobe in cycle 1, done in cycle 2.
  - Read: rd_strobe in cycle 1, done in cycle 2 + RD_LATENCY, with rdata valid in that cycle.
- mN_rdata holds its value until that master's next read completes. It is unaffected by writes or by the other master.
- Requests arriving during ISSUE, WAIT or DONE wait for IDLE; they are never dropped.
- Back-to-back use: a master may re-request no earlier than the cycle after its IDLE.
- Fairness: two continuously requesting masters strictly alternate.

Test Plan:
- Reset, then m0 writes addr 0x10, data 0xA5, strobe 0xF:
  - s_wr_strobe = 0xF for exactly one cycle, 1 cycle after the grant.
  - m0_done pulses 2 cycles after the grant.
  - Slave LED register = 0xA5.
- m0 reads after that write, RD_LATENCY=1:
  - s_rd_strobe pulses once.
  - m0_done occurs 3 cycles after the grant, with m0_rdata = 0x000000A5.
  - m1_rdata stays 0.
- m0 and m1 request in the same cycle immediately after reset:
  - m0 is granted first, then m1.
  - With both held requesting for 4 transactions, the grant order is 0,1,0,1.
- m1 asserts rd and wr_strobe = 0x3 together:
  - Only s_rd_strobe fires; s_wr_strobe stays 0.
  - The slave register is unchanged.
- rst driven low during WAIT of an m1 read:
  - All outputs are 0 immediately; no m1_done.
  - After release, an m0 request is granted first (last_grant reset).
- RD_LATENCY=3 build:
  - Read done arrives 5 cycles after the grant.
  - s_rdata is captured in the correct cycle; a bench slave that changes data one cycle late must be detected.
